// File: rtl/fetch_issue_unit.sv
// Instruction fetch/issue sequencer: owns the PC and the instruction register, fetches over a
// req/ack handshake, issues decoded fields, and selects the next PC from control-unit outputs.
module fetch_issue_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [2:0]  opcode,
  output logic [2:0]  rs,
  output logic [2:0]  rt,
  output logic [2:0]  rd,
  output logic [6:0]  imm7,
  output logic [12:0] jaddr,
  output logic        instr_valid,
  input  logic        issue_ready,
  input  logic        Branch,
  input  logic [1:0]  PCSrc,
  input  logic        alu_zero,
  input  logic [15:0] jr_target,
  output logic [15:0] pc
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_plus1;
  logic [15:0] next_pc;

  assign pc_plus1 = pc_q + 16'd1;

  always_comb begin
    next_pc = pc_plus1;
    unique case (PCSrc)
      2'b00: next_pc = pc_plus1;
      2'b01: begin
        if (Branch && alu_zero) begin
          next_pc = pc_plus1 + {{9{ir_q[6]}}, ir_q[6:0]};
        end
      end
      2'b10: next_pc = {pc_q[15:13], ir_q[12:0]};
      2'b11: next_pc = jr_target;
      default: next_pc = pc_plus1;
    endcase
  end

  // req/valid are computed for the next state so they come straight out of flops.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = 1'b0;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          req_d   = 1'b1;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StIssue;
          valid_d = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      StIssue: begin
        if (issue_ready) begin
          pc_d = next_pc;
          if (run) begin
            state_d = StFetch;
            req_d   = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign opcode      = ir_q[15:13];
  assign rs          = ir_q[12:10];
  assign rt          = ir_q[9:7];
  assign rd          = ir_q[6:4];
  assign imm7        = ir_q[6:0];
  assign jaddr       = ir_q[12:0];

endmodule
